// File: rtl/bsg_dff_en_rr_share.sv
// Single-entry shared holding register fed by els_p requesters under round-robin
// arbitration; valid/ready on the producer side, valid/yumi on the consumer side.

module bsg_dff_en_rr_share_chk #(
    parameter int els_p = 4
) (
    input logic             clk_i,
    input logic             reset_i,
    input logic             v_o,
    input logic             yumi_i,
    input logic [els_p-1:0] ready_o
);

    // consumer may only yumi a valid entry, and at most one requester is granted
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o is low");
            assert ($onehot0(ready_o)) else $error("ready_o is not one-hot-or-zero");
        end
    end

endmodule

module bsg_dff_en_rr_share #(
    parameter int  width_p   = 16,
    parameter int  els_p     = 4,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p*width_p-1:0] data_i,
    output logic [els_p-1:0]         ready_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic [lg_els_lp-1:0]     id_o,
    input  logic                     yumi_i
);

    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e                 state_r;
    state_e                 state_next_s;
    logic [lg_els_lp-1:0]   ptr_r;
    logic [lg_els_lp-1:0]   id_r;
    logic [width_p-1:0]     data_r;
    logic                   accept_s;
    logic                   xfer_s;
    logic                   found_s;
    logic [els_p-1:0]       grant_s;
    logic [lg_els_lp-1:0]   grant_id_s;
    logic [lg_els_lp-1:0]   ptr_next_s;
    logic [width_p-1:0]     grant_data_s;
    int                     dist_s;
    int                     best_dist_s;

    // rotating-priority search: winner is the valid requester closest to ptr going upward
    always_comb begin
        grant_s      = '0;
        grant_id_s   = '0;
        grant_data_s = '0;
        found_s      = 1'b0;
        best_dist_s  = els_p;
        dist_s       = 0;
        for (int k = 0; k < els_p; k++) begin
            if (k >= int'(ptr_r)) begin
                dist_s = k - int'(ptr_r);
            end else begin
                dist_s = k + els_p - int'(ptr_r);
            end
            if (v_i[k] && (dist_s < best_dist_s)) begin
                best_dist_s  = dist_s;
                grant_s      = '0;
                grant_s[k]   = 1'b1;
                grant_id_s   = lg_els_lp'(k);
                grant_data_s = data_i[k*width_p +: width_p];
                found_s      = 1'b1;
            end else begin
                best_dist_s  = best_dist_s;
            end
        end
    end

    // next fairness pointer wraps explicitly so non-power-of-two els_p stays in range
    always_comb begin
        if (grant_id_s == lg_els_lp'(els_p - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_id_s + lg_els_lp'(1);
        end
    end

    // occupancy state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state logic: a transfer always wins over a drain
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (xfer_s) state_next_s = ST_FULL;
                else        state_next_s = ST_EMPTY;
            end
            ST_FULL: begin
                if (xfer_s)      state_next_s = ST_FULL;
                else if (yumi_i) state_next_s = ST_EMPTY;
                else             state_next_s = ST_FULL;
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // output logic; yumi_i to ready_o is a deliberate combinational path
    always_comb begin
        accept_s = (state_r == ST_EMPTY) | yumi_i;
        if (accept_s && !reset_i) begin
            ready_o = grant_s;
            xfer_s  = found_s;
        end else begin
            ready_o = '0;
            xfer_s  = 1'b0;
        end
        v_o = (state_r == ST_FULL);
    end

    // enabled data/id/pointer bank; loads only on a transfer
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r <= '0;
            id_r   <= '0;
            ptr_r  <= '0;
        end else if (xfer_s) begin
            data_r <= grant_data_s;
            id_r   <= grant_id_s;
            ptr_r  <= ptr_next_s;
        end else begin
            data_r <= data_r;
            id_r   <= id_r;
            ptr_r  <= ptr_r;
        end
    end

    assign data_o = data_r;
    assign id_o   = id_r;

    bsg_dff_en_rr_share_chk #(.els_p(els_p)) u_chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_o     (v_o),
        .yumi_i  (yumi_i),
        .ready_o (ready_o)
    );

endmodule

// File: tb/tb_bsg_dff_en_rr_share.sv
// Bench for bsg_dff_en_rr_share: a 4-requester and a 3-requester instance run in
// lockstep against a queue-free behavioural model of the round-robin share register.

module tb_bsg_dff_en_rr_share;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  v4, ready4;
    logic [63:0] data4;
    logic        yumi4, vo4;
    logic [15:0] do4;
    logic [1:0]  id4;
    logic [2:0]  v3, ready3;
    logic [47:0] data3;
    logic        yumi3, vo3;
    logic [15:0] do3;
    logic [1:0]  id3;

    int checks = 0;
    int errors = 0;

    int          m_ptr  [2];
    int          m_id   [2];
    bit          m_full [2];
    logic [15:0] m_data [2];
    int          els    [2] = '{4, 3};

    bsg_dff_en_rr_share #(.width_p(16), .els_p(4)) u_dut4 (
        .clk_i(clk), .reset_i(reset), .v_i(v4), .data_i(data4), .ready_o(ready4),
        .v_o(vo4), .data_o(do4), .id_o(id4), .yumi_i(yumi4)
    );

    bsg_dff_en_rr_share #(.width_p(16), .els_p(3)) u_dut3 (
        .clk_i(clk), .reset_i(reset), .v_i(v3), .data_i(data3), .ready_o(ready3),
        .v_o(vo3), .data_o(do3), .id_o(id3), .yumi_i(yumi3)
    );

    function automatic int pick(int n, int ptr, logic [3:0] v);
        for (int off = 0; off < n; off++) begin
            int k;
            k = (ptr + off) % n;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(logic [3:0] v, bit yumi_req, bit rst, bit fix, logic [15:0] fixval);
        logic [15:0] sl [4];
        logic [3:0]  vv [2];
        int          g  [2];
        bit          acc[2];
        bit          yu [2];
        for (int i = 0; i < 4; i++) sl[i] = fix ? fixval : 16'($urandom);
        reset = rst;
        v4    = v;
        v3    = v[2:0];
        data4 = {sl[3], sl[2], sl[1], sl[0]};
        data3 = {sl[2], sl[1], sl[0]};
        yumi4 = yumi_req & m_full[0];
        yumi3 = yumi_req & m_full[1];
        yu[0] = yumi4;
        yu[1] = yumi3;
        vv[0] = v;
        vv[1] = {1'b0, v[2:0]};
        for (int d = 0; d < 2; d++) begin
            acc[d] = !m_full[d] || yu[d];
            g[d]   = pick(els[d], m_ptr[d], vv[d]);
        end
        #2;
        chk("ready4", {28'd0, ready4}, (!rst && acc[0] && g[0] >= 0) ? (32'd1 << g[0]) : 32'd0);
        chk("ready3", {29'd0, ready3}, (!rst && acc[1] && g[1] >= 0) ? (32'd1 << g[1]) : 32'd0);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_full[d] = 1'b0;
                m_data[d] = 16'h0000;
                m_id[d]   = 0;
                m_ptr[d]  = 0;
            end else if (acc[d] && g[d] >= 0) begin
                m_full[d] = 1'b1;
                m_data[d] = sl[g[d]];
                m_id[d]   = g[d];
                m_ptr[d]  = (g[d] + 1) % els[d];
            end else if (m_full[d] && yu[d]) begin
                m_full[d] = 1'b0;
            end
        end
        #1;
        chk("v_o4",   {31'd0, vo4}, {31'd0, m_full[0]});
        chk("data4",  {16'd0, do4}, {16'd0, m_data[0]});
        chk("id4",    {30'd0, id4}, 32'(m_id[0]));
        chk("v_o3",   {31'd0, vo3}, {31'd0, m_full[1]});
        chk("data3",  {16'd0, do3}, {16'd0, m_data[1]});
        chk("id3",    {30'd0, id3}, 32'(m_id[1]));
    endtask

    int seq4 [6] = '{0, 1, 2, 3, 0, 1};
    int seq3 [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 1'b0;
            m_data[d] = 16'h0000;
            m_id[d]   = 0;
            m_ptr[d]  = 0;
        end
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 16'h0000);

        // idle after reset
        repeat (5) cycle(4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000);

        // single requester 2 fills the register, then holds with no yumi
        cycle(4'b0100, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        chk("fill_data", {16'd0, do4}, 32'h0000BEEF);
        chk("fill_id",   {30'd0, id4}, 32'd2);
        cycle(4'b1111, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("hold_data", {16'd0, do4}, 32'h0000BEEF);

        // all requesting with yumi every cycle: back-to-back round robin
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 1'b1, 1'b0, 1'b0, 16'h0000);
            chk("rr_id4", {30'd0, id4}, 32'(seq4[i]));
            chk("rr_id3", {30'd0, id3}, 32'(seq3[i]));
        end

        // drain leaves the pointer alone
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(4'b0010, 1'b0, 1'b0, 1'b1, 16'h1234);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("drain_v", {31'd0, vo4}, 32'd0);
        cycle(4'b0101, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("after_drain_id", {30'd0, id4}, 32'd2);

        // reset colliding with a transfer
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(4'b0010, 1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(4'b1111, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("rst_v", {31'd0, vo4}, 32'd0);
        chk("rst_data", {16'd0, do4}, 32'd0);
        cycle(4'b1111, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rst_ptr_id", {30'd0, id4}, 32'd0);

        // randomized traffic with occasional reset
        repeat (400) begin
            cycle(4'($urandom), 1'($urandom_range(0, 1)), (($urandom_range(0, 40)) == 0), 1'b0, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_dff_en_rr_share.md
Name: bsg_dff_en_rr_share

Overview:
- Single-entry shared holding register, built from a `bsg_dff_en`-style enabled register bank of width_p bits.
- Shared by els_p requesters under round-robin arbitration, with a valid/ready handshake on the input side and valid/yumi on the output side.
- Sits between several producers (e.g. config or CSR writers) and one consumer that drains the shared register.
- The block generates the register enable, tracks the occupancy state, the owner id and the fairness pointer.

Parameters:
- width_p, 16, data width of each requester and of the shared register.
- els_p, 4, number of requesters; legal range 1..16.
- lg_els_lp, derived as max(1, ceil(log2(els_p))), width of id_o; not user-set.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  els_p  per-requester valid.
- data_i  input  els_p*width_p  requester k drives bits [k*width_p +: width_p].
- ready_o  output  els_p  one-hot-or-zero grant; requester k transfers when v_i[k] & ready_o[k].
- v_o  output  1  shared register holds valid data.
- data_o  output  width_p  shared register contents; registered.
- id_o  output  lg_els_lp  index of the requester whose data is in data_o; registered.
- yumi_i  input  1  consumer takes data_o this cycle; legal only when v_o=1.

Behaviour:
- State machine has two states. EMPTY means v_o=0. FULL means v_o=1.
- Reset (reset_i=1 at posedge):
  - state=EMPTY, v_o=0, data_o=0, id_o=0, rr pointer=0.
  - ready_o=0 while reset_i=1.
  - Reset overrides every other event in the same cycle, including a transfer or yumi mid-operation.
- Accept condition: accept = (state==EMPTY) | yumi_i. This is a combinational path from yumi_i to ready_o and is intentional.
- Grant:
  - When accept=1, ready_o[k]=1 for exactly one k: the first index with v_i[k]=1, searching k = ptr, ptr+1, ..., wrapping modulo els_p.
  - If no v_i is set, ready_o=0.
  - When accept=0, ready_o=0.
  - ready_o depends combinationally on v_i.
- Transfer (some v_i[k] & ready_o[k]) at posedge:
  - Register enable asserted; data_o <= data_i slice k; id_o <= k; state <= FULL.
  - ptr <= (k+1) mod els_p, with explicit wrap, so non-power-of-two els_p never indexes ≥ els_p.
- Drain only (FULL, yumi_i=1, no transfer): state <= EMPTY, v_o <= 0. data_o and id_o hold their old values; they are don't-care to the consumer.
- Simultaneous yumi and transfer (FULL, yumi_i=1, transfer): the new data is loaded and state stays FULL. This gives back-to-back throughput of 1 item per cycle.
- No-activity cycles: FULL without yumi holds data_o, id_o and ptr stable. Registered outputs change only on a transfer.
- Pointer update: ptr updates only on a transfer, never on a drain.
- Latency: v_i to v_o is 1 cycle, with data valid the cycle after the transfer.
- Fairness: after requester k is granted, each other continuously requesting requester is granted before k again, so no requester starves.
- Illegal yumi: yumi_i=1 with v_o=0 is illegal. The simulation assertion fires; in hardware it is treated as a no-op beyond enabling accept, which already holds in EMPTY.
- Single requester (els_p=1): id_o is always 0, ptr is constant 0, and ready_o[0] = accept & v_i[0].
- X-safety: no output may go X after reset when the inputs are known.

Test Plan:
1. Reset, then v_i=4'b0000 for 5 cycles -> v_o=0, ready_o=0, data_o=16'h0000, id_o=0 throughout.
2. EMPTY, v_i=4'b0100 with data slice2=16'hBEEF -> ready_o=4'b0100 that cycle; next cycle v_o=1, data_o=16'hBEEF, id_o=2, and ready_o=0 while yumi_i=0.
3. v_i=4'b1111 held, yumi_i=1 every cycle after the first fill -> grants in the order 0,1,2,3,0,1; id_o follows that sequence one cycle later; v_o stays 1 with no bubbles.
4. els_p=3 build, v_i=3'b111 held with yumi_i=1 -> grant order 0,1,2,0; ptr never reaches 3 and there is no X on id_o.
5. FULL with data 16'h1234, yumi_i=1, v_i=0 -> next cycle v_o=0 and ptr unchanged; a later v_i=4'b0001 is granted per the unchanged ptr.
6. FULL, transfer and reset_i=1 in the same cycle -> next cycle v_o=0, data_o=0, id_o=0, and the pointer is back at 0.
